// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, ALU ops,
// writeback selects, FSM states and immediate formats.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_PASSB = 4'hF;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB, ST_HALT, ST_ERR
    } state_t;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_sel_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate generator: I/S/B/U/J field extraction, sign-extended to XLEN.
// Latency: combinational. Backpressure: none.
// Unselected format yields zero.
module rv_imm_gen
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = 32'h0;
        case (sel)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'h000};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = 32'h0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM owning PC/IR, decode and memory handshakes.
// Latency: ALU 5, load 6, store 5, branch 4 cycles with zero-wait memories.
// Backpressure: req held until ack; missing ack for MEM_TIMEOUT cycles -> ERR.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter int               MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    input  logic            imem_err,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    input  logic            dmem_err,
    input  logic [XLEN-1:0] alu_res,
    input  logic            br_taken,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      alu_op,
    output logic            op1_pc,
    output logic            op2_imm,
    output logic [1:0]      wb_sel,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic            halted,
    output logic            err
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t          state, state_nxt, state_run;
    imm_sel_t        imm_sel;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_hit;
    logic [XLEN-1:0] pc4, tgt;
    logic            pc_we, ir_we;
    logic            is_load, is_store, is_branch, is_jal, is_jalr, is_sys, rd_wr, illegal;
    logic [2:0]      funct3;

    assign funct3    = instr[14:12];
    assign pc4       = pc + XLEN'(4);
    assign state_run = start ? ST_IF : ST_IDLE;
    assign tmo_hit   = (MEM_TIMEOUT != 0) && (tmo_cnt == TW'(MEM_TIMEOUT - 1));

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instr),
        .sel   (imm_sel),
        .imm   (imm)
    );

    always_comb begin
        imm_sel   = IMM_NONE;
        alu_op    = ALU_ADD;
        op1_pc    = 1'b0;
        op2_imm   = 1'b0;
        wb_sel    = WB_ALU;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_sys    = 1'b0;
        rd_wr     = 1'b0;
        illegal   = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                alu_op = {instr[30], funct3};
                rd_wr  = 1'b1;
            end
            OPC_OPIMM: begin
                // Only shifts carry an op modifier in bit 30; elsewhere it is immediate data.
                alu_op  = (funct3 == 3'b101) ? {instr[30], funct3} : {1'b0, funct3};
                op2_imm = 1'b1;
                imm_sel = IMM_I;
                rd_wr   = 1'b1;
            end
            OPC_LUI: begin
                alu_op  = ALU_PASSB;
                op2_imm = 1'b1;
                imm_sel = IMM_U;
                rd_wr   = 1'b1;
            end
            OPC_AUIPC: begin
                op1_pc  = 1'b1;
                op2_imm = 1'b1;
                imm_sel = IMM_U;
                rd_wr   = 1'b1;
            end
            OPC_JAL: begin
                op1_pc  = 1'b1;
                op2_imm = 1'b1;
                imm_sel = IMM_J;
                wb_sel  = WB_PC4;
                rd_wr   = 1'b1;
                is_jal  = 1'b1;
            end
            OPC_JALR: begin
                op2_imm = 1'b1;
                imm_sel = IMM_I;
                wb_sel  = WB_PC4;
                rd_wr   = 1'b1;
                is_jalr = 1'b1;
            end
            OPC_BRANCH: begin
                op1_pc    = 1'b1;
                op2_imm   = 1'b1;
                imm_sel   = IMM_B;
                is_branch = 1'b1;
            end
            OPC_LOAD: begin
                op2_imm = 1'b1;
                imm_sel = IMM_I;
                wb_sel  = WB_MEM;
                rd_wr   = 1'b1;
                is_load = 1'b1;
            end
            OPC_STORE: begin
                op2_imm  = 1'b1;
                imm_sel  = IMM_S;
                is_store = 1'b1;
            end
            OPC_FENCE: ;
            OPC_SYSTEM: begin
                is_sys  = (funct3 == 3'b000);
                illegal = (funct3 != 3'b000);
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        tgt       = pc4;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_IF;
            ST_IF: begin
                if (imem_err) begin
                    state_nxt = ST_ERR;
                end else if (imem_ack) begin
                    ir_we     = 1'b1;
                    state_nxt = ST_ID;
                end else if (tmo_hit) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ID: begin
                if (illegal)     state_nxt = ST_ERR;
                else if (is_sys) state_nxt = ST_HALT;
                else             state_nxt = ST_EX;
            end
            ST_EX: begin
                if (is_load || is_store) begin
                    state_nxt = ST_MEM;
                end else if (is_branch) begin
                    tgt       = br_taken ? alu_res : pc4;
                    pc_we     = ~tgt[1];
                    state_nxt = tgt[1] ? ST_ERR : state_run;
                end else begin
                    state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_err) begin
                    state_nxt = ST_ERR;
                end else if (dmem_ack) begin
                    if (is_load) begin
                        state_nxt = ST_WB;
                    end else begin
                        pc_we     = ~tgt[1];
                        state_nxt = tgt[1] ? ST_ERR : state_run;
                    end
                end else if (tmo_hit) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_WB: begin
                if (is_jal)       tgt = alu_res;
                else if (is_jalr) tgt = {alu_res[XLEN-1:1], 1'b0};
                // A misaligned target aborts the whole instruction, including its writeback.
                pc_we     = ~tgt[1];
                rf_we     = ~tgt[1] && rd_wr && (instr[11:7] != 5'd0);
                state_nxt = tgt[1] ? ST_ERR : state_run;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            instr   <= '0;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (pc_we) pc <= tgt;
            if (ir_we) instr <= imem_rdata;
            tmo_cnt <= (state_nxt != state) ? '0 : tmo_cnt + TW'(1);
        end
    end

    assign imem_req  = (state == ST_IF);
    assign imem_addr = pc;
    assign dmem_req  = (state == ST_MEM);
    assign dmem_we   = (state == ST_MEM) && is_store;
    assign rf_waddr  = instr[11:7];
    assign halted    = (state == ST_HALT);
    assign err       = (state == ST_ERR);

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: reset, ALU op, branch, delayed load,
// fetch timeout, JALR alignment, halt, start drop and mid-MEM reset.
module tb_rv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        imem_req, imem_ack, imem_err;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack, dmem_err;
    logic [31:0] alu_res, pc, instr, imm;
    logic        br_taken, op1_pc, op2_imm, rf_we, halted, err;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
    logic [4:0]  rf_waddr;
    logic        im_auto;
    int          errors = 0;
    int          checks = 0;
    int          req_cycles;

    always #5 clk = ~clk;

    // Zero-wait instruction memory when im_auto is set; otherwise it never answers.
    assign imem_ack = im_auto & imem_req;

    rv_multicycle_ctrl #(.XLEN(32), .RESET_PC(32'h0), .MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .imem_err   (imem_err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .dmem_err   (dmem_err),
        .alu_res    (alu_res),
        .br_taken   (br_taken),
        .pc         (pc),
        .instr      (instr),
        .imm        (imm),
        .alu_op     (alu_op),
        .op1_pc     (op1_pc),
        .op2_imm    (op2_imm),
        .wb_sel     (wb_sel),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .halted     (halted),
        .err        (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0; im_auto = 1'b1;
        dmem_ack = 1'b0; dmem_err = 1'b0; alu_res = 32'h0; br_taken = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_imm", imm, 32'h0);
        check("rst_alu_op", {28'h0, alu_op}, 32'h0);
        check("rst_sel", {29'h0, op1_pc, wb_sel}, 32'h0);
        check("rst_reqs", {29'h0, imem_req, dmem_req, rf_we}, 32'h0);
        check("rst_flags", {30'h0, halted, err}, 32'h0);

        // addi x1,x0,5
        imem_rdata = 32'h00500093; start = 1'b1;
        tick();
        check("addi_if_req", {31'h0, imem_req}, 32'h1);
        check("addi_if_addr", imem_addr, 32'h0);
        tick();
        check("addi_id_instr", instr, 32'h00500093);
        tick();
        check("addi_ex_imm", imm, 32'h5);
        check("addi_ex_alu_op", {28'h0, alu_op}, 32'h0);
        check("addi_ex_op2_imm", {31'h0, op2_imm}, 32'h1);
        check("addi_ex_rf_we", {31'h0, rf_we}, 32'h0);
        alu_res = 32'h5; start = 1'b0;
        tick();
        check("addi_wb_rf_we", {31'h0, rf_we}, 32'h1);
        check("addi_wb_waddr", {27'h0, rf_waddr}, 32'h1);
        check("addi_wb_sel", {30'h0, wb_sel}, 32'h0);
        tick();
        check("addi_pc", pc, 32'h4);
        check("addi_idle_rf_we", {31'h0, rf_we}, 32'h0);

        // beq x0,x0,+0x40 taken, ALU supplies 0x40
        imem_rdata = 32'h04000063; start = 1'b1;
        tick();
        check("beq_if_addr", imem_addr, 32'h4);
        tick();
        check("beq_id_rf_we", {31'h0, rf_we}, 32'h0);
        tick();
        check("beq_ex_imm", imm, 32'h40);
        check("beq_ex_op1_pc", {31'h0, op1_pc}, 32'h1);
        check("beq_ex_rf_we", {31'h0, rf_we}, 32'h0);
        alu_res = 32'h40; br_taken = 1'b1; start = 1'b0;
        tick();
        check("beq_pc", pc, 32'h40);
        check("beq_idle_rf_we", {31'h0, rf_we}, 32'h0);
        br_taken = 1'b0;

        // lw x5,8(x1) with dmem_ack three cycles late
        imem_rdata = 32'h0080A283; start = 1'b1;
        tick(); tick(); tick();
        check("lw_ex_imm", imm, 32'h8);
        alu_res = 32'h48;
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dmem_req === 1'b1 && dmem_we === 1'b0) req_cycles++;
            if (i == 3) dmem_ack = 1'b1;
        end
        check("lw_req_cycles", req_cycles, 32'd4);
        start = 1'b0;
        tick();
        dmem_ack = 1'b0;
        check("lw_wb_dmem_req", {31'h0, dmem_req}, 32'h0);
        check("lw_wb_sel", {30'h0, wb_sel}, 32'h1);
        check("lw_wb_rf_we", {31'h0, rf_we}, 32'h1);
        check("lw_wb_waddr", {27'h0, rf_waddr}, 32'h5);
        tick();
        check("lw_pc", pc, 32'h44);

        // fetch never acknowledged
        im_auto = 1'b0; start = 1'b1;
        req_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (imem_req === 1'b1 && imem_addr === 32'h44 && err === 1'b0) req_cycles++;
        end
        check("tmo_if_cycles", req_cycles, 32'd16);
        tick();
        check("tmo_err", {31'h0, err}, 32'h1);
        check("tmo_req_drop", {31'h0, imem_req}, 32'h0);
        tick();
        check("tmo_err_sticky", {31'h0, err}, 32'h1);
        check("tmo_pc", pc, 32'h44);

        // jalr x1,0(x2) to 0x103 -> misaligned
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_clears_err", {31'h0, err}, 32'h0);
        im_auto = 1'b1; imem_rdata = 32'h000100E7; start = 1'b1;
        tick(); tick(); tick();
        check("jalr_ex_sel", {29'h0, op1_pc, op2_imm, 1'b0} | {30'h0, wb_sel == 2'd2, 1'b0}, 32'h3 - 32'h1);
        alu_res = 32'h103;
        tick();
        check("jalr_bad_rf_we", {31'h0, rf_we}, 32'h0);
        tick();
        check("jalr_bad_err", {31'h0, err}, 32'h1);
        check("jalr_bad_pc", pc, 32'h0);

        // same jalr to 0x101 -> 0x100
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1;
        tick(); tick(); tick();
        alu_res = 32'h101; start = 1'b0;
        tick();
        check("jalr_ok_rf_we", {31'h0, rf_we}, 32'h1);
        check("jalr_ok_wb_sel", {30'h0, wb_sel}, 32'h2);
        tick();
        check("jalr_ok_pc", pc, 32'h100);
        check("jalr_ok_err", {31'h0, err}, 32'h0);

        // ecall halts
        imem_rdata = 32'h00000073; start = 1'b1;
        tick(); tick(); tick();
        check("ecall_halted", {31'h0, halted}, 32'h1);
        check("ecall_no_req", {30'h0, imem_req, dmem_req}, 32'h0);
        tick();
        check("ecall_sticky", {31'h0, halted}, 32'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_clears_halt", {31'h0, halted}, 32'h0);

        // addi x2,x0,1 with start dropped during fetch
        imem_rdata = 32'h00100113; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("drop_wb_rf_we", {31'h0, rf_we}, 32'h1);
        tick();
        check("drop_pc", pc, 32'h4);
        tick();
        check("drop_idle_req", {31'h0, imem_req}, 32'h0);
        check("drop_idle_pc", pc, 32'h4);

        // sw x0,0(x0), reset while waiting in MEM
        imem_rdata = 32'h00002023; start = 1'b1;
        tick(); tick(); tick(); tick();
        check("sw_mem_req", {30'h0, dmem_req, dmem_we}, 32'h3);
        rst = 1'b1;
        tick();
        check("mem_rst_pc", pc, 32'h0);
        check("mem_rst_req", {31'h0, dmem_req}, 32'h0);
        rst = 1'b0; start = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
